// File: rtl/mmu_controller_if.sv
// rtl/mmu_controller_if.sv - CPU-side and physical-RAM-side signal bundle for mmu_controller
//
// master: the environment (CPU request path plus physical RAM)
// slave : the mmu_controller
//   mcRamAddress/mcRamIn/mcReadReq/mcWriteReq/mcAddrVirtual  CPU request
//   ptAddress/tlbFlush                                       page table base, TLB flush
//   mcRamOut/mcRamReady/mcFault                              CPU response
//   phRamAddress/phRamOut/phReadReq/phWriteReq/phRamIn       physical RAM port
//   debug                                                    {missCount, hitCount}
interface mmu_controller_if;
  logic [31:0] mcRamAddress;
  logic [31:0] mcRamIn;
  logic        mcReadReq;
  logic        mcWriteReq;
  logic        mcAddrVirtual;
  logic [31:0] ptAddress;
  logic        tlbFlush;
  logic [31:0] mcRamOut;
  logic        mcRamReady;
  logic        mcFault;
  logic [31:0] phRamIn;
  logic [31:0] phRamAddress;
  logic [31:0] phRamOut;
  logic        phReadReq;
  logic        phWriteReq;
  logic [31:0] debug;

  modport master (
    output mcRamAddress, mcRamIn, mcReadReq, mcWriteReq, mcAddrVirtual,
           ptAddress, tlbFlush, phRamIn,
    input  mcRamOut, mcRamReady, mcFault, phRamAddress, phRamOut,
           phReadReq, phWriteReq, debug
  );

  modport slave (
    input  mcRamAddress, mcRamIn, mcReadReq, mcWriteReq, mcAddrVirtual,
           ptAddress, tlbFlush, phRamIn,
    output mcRamOut, mcRamReady, mcFault, phRamAddress, phRamOut,
           phReadReq, phWriteReq, debug
  );
endinterface

// File: rtl/mmu_controller.sv
// rtl/mmu_controller.sv - virtual-to-physical memory controller with direct-mapped TLB and page-table walk
//
// Ports:
//   clk    global clock
//   reset  synchronous, active-low reset
//   bus    mmu_controller_if.slave (CPU request/response, physical RAM port, debug counters)
module mmu_controller #(
  parameter int PAGE_BITS      = 10,
  parameter int TLB_INDEX_BITS = 4,
  parameter int PT_INDEX_BITS  = 8,
  parameter int RAM_LATENCY    = 2
) (
  input logic             clk,
  input logic             reset,
  mmu_controller_if.slave bus
);
  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int TLB_N = 1 << TLB_INDEX_BITS;
  localparam int CW    = $clog2(RAM_LATENCY + 1);

  localparam logic [2:0] READY     = 3'd0;
  localparam logic [2:0] PHYS_WAIT = 3'd1;
  localparam logic [2:0] PT_WAIT0  = 3'd2;
  localparam logic [2:0] PT_WAIT1  = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    wait_cnt;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic             req_write;
  logic             pt_writable;
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  logic [TLB_N-1:0] tlb_valid;
  logic             tlb_writable [TLB_N];
  logic [VPN_W-1:0] tlb_tag      [TLB_N];
  logic [VPN_W-1:0] tlb_ppn      [TLB_N];

  logic                      req;
  logic                      req_wr;
  logic [VPN_W-1:0]          vpn;
  logic [TLB_INDEX_BITS-1:0] tlb_idx;
  logic [PT_INDEX_BITS-1:0]  pt_idx;
  logic                      in_range;
  logic                      tlb_hit;
  logic [31:0]               pt_entry;
  logic                      wait_done;
  logic                      fill_en;
  logic [TLB_INDEX_BITS-1:0] fill_idx;

  assign req       = bus.mcReadReq | bus.mcWriteReq;
  assign req_wr    = bus.mcWriteReq & ~bus.mcReadReq;   // read wins when both strobes are set
  assign vpn       = bus.mcRamAddress[31:PAGE_BITS];
  assign tlb_idx   = bus.mcRamAddress[PAGE_BITS +: TLB_INDEX_BITS];
  assign pt_idx    = bus.mcRamAddress[PAGE_BITS +: PT_INDEX_BITS];
  assign in_range  = (vpn >> PT_INDEX_BITS) == '0;
  assign tlb_hit   = tlb_valid[tlb_idx] && (tlb_tag[tlb_idx] == vpn);
  assign pt_entry  = bus.ptAddress + 32'({pt_idx, 3'b000});   // wraps modulo 2^32
  assign wait_done = (wait_cnt == CW'(RAM_LATENCY));
  assign fill_en   = (state == PT_WAIT1) && wait_done;
  assign fill_idx  = req_addr[PAGE_BITS +: TLB_INDEX_BITS];
  assign bus.debug = {miss_count, hit_count};

  // Flush beats a same-edge fill; the in-flight access uses phRamIn directly, so it still completes.
  always_ff @(posedge clk) begin
    if (!reset || bus.tlbFlush) begin
      tlb_valid <= '0;
    end else if (fill_en) begin
      tlb_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tlb_tag[fill_idx]      <= req_addr[31:PAGE_BITS];
      tlb_ppn[fill_idx]      <= bus.phRamIn[VPN_W-1:0];
      tlb_writable[fill_idx] <= pt_writable;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= READY;
      wait_cnt         <= '0;
      req_addr         <= '0;
      req_data         <= '0;
      req_write        <= 1'b0;
      pt_writable      <= 1'b0;
      hit_count        <= '0;
      miss_count       <= '0;
      bus.mcRamOut     <= '0;
      bus.mcRamReady   <= 1'b0;
      bus.mcFault      <= 1'b0;
      bus.phRamAddress <= '0;
      bus.phRamOut     <= '0;
      bus.phReadReq    <= 1'b0;
      bus.phWriteReq   <= 1'b0;
    end else begin
      bus.mcRamReady <= 1'b0;
      bus.mcFault    <= 1'b0;
      case (state)
        READY: begin
          bus.phReadReq  <= 1'b0;
          bus.phWriteReq <= 1'b0;
          if (req) begin
            req_addr  <= bus.mcRamAddress;
            req_data  <= bus.mcRamIn;
            req_write <= req_wr;
            wait_cnt  <= CW'(1);
            if (!bus.mcAddrVirtual) begin
              bus.phRamAddress <= bus.mcRamAddress;
              bus.phRamOut     <= bus.mcRamIn;
              bus.phReadReq    <= ~req_wr;
              bus.phWriteReq   <= req_wr;
              state            <= PHYS_WAIT;
            end else if (!in_range) begin
              state <= FAULT;
            end else if (tlb_hit) begin
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
              if (req_wr && !tlb_writable[tlb_idx]) begin
                state <= FAULT;
              end else begin
                bus.phRamAddress <= {tlb_ppn[tlb_idx], bus.mcRamAddress[PAGE_BITS-1:0]};
                bus.phRamOut     <= bus.mcRamIn;
                bus.phReadReq    <= ~req_wr;
                bus.phWriteReq   <= req_wr;
                state            <= PHYS_WAIT;
              end
            end else begin
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
              bus.phRamAddress <= pt_entry;
              bus.phReadReq    <= 1'b1;
              state            <= PT_WAIT0;
            end
          end
        end
        PHYS_WAIT: begin
          if (wait_done) begin
            if (!req_write) bus.mcRamOut <= bus.phRamIn;
            bus.mcRamReady <= 1'b1;
            bus.phReadReq  <= 1'b0;
            bus.phWriteReq <= 1'b0;
            state          <= READY;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        PT_WAIT0: begin
          // word0: bit31 valid, bit30 writable
          if (wait_done) begin
            if (!bus.phRamIn[31] || (req_write && !bus.phRamIn[30])) begin
              bus.phReadReq <= 1'b0;
              state         <= FAULT;
            end else begin
              pt_writable      <= bus.phRamIn[30];
              bus.phRamAddress <= bus.phRamAddress + 32'd4;
              wait_cnt         <= CW'(1);
              state            <= PT_WAIT1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        PT_WAIT1: begin
          if (wait_done) begin
            bus.phRamAddress <= {bus.phRamIn[VPN_W-1:0], req_addr[PAGE_BITS-1:0]};
            bus.phRamOut     <= req_data;
            bus.phReadReq    <= ~req_write;
            bus.phWriteReq   <= req_write;
            wait_cnt         <= CW'(1);
            state            <= PHYS_WAIT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FAULT: begin
          bus.mcRamReady <= 1'b1;
          bus.mcFault    <= 1'b1;
          state          <= READY;
        end
        default: state <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_controller.sv
// tb/tb_mmu_controller.sv - randomized scoreboard testbench for mmu_controller
module tb_mmu_controller;
  localparam int L       = 2;
  localparam int PT_BASE = 32'h2000;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int unsigned ready_cyc;
    logic [31:0] debug;
    logic        strobes;
    logic        wrote;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmu_controller_if bus();

  mmu_controller #(
    .PAGE_BITS(10), .TLB_INDEX_BITS(4), .PT_INDEX_BITS(8), .RAM_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // physical RAM: 16 KB, combinational read, written on each edge a write strobe is held
  logic [31:0] mem [0:4095];
  logic        init_we = 1'b0;
  logic [11:0] init_a  = '0;
  logic [31:0] init_d  = '0;
  assign bus.phRamIn = mem[bus.phRamAddress[13:2]];
  always @(posedge clk) begin
    if (init_we) mem[init_a] <= init_d;
    else if (bus.phWriteReq) mem[bus.phRamAddress[13:2]] <= bus.phRamOut;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [31:0] ref_mem [0:4095];
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_ppn [16];
  bit          m_w   [16];
  int unsigned hits = 0, misses = 0;
  logic [31:0] last_out = '0;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   strobe_cycles = 0, write_cycles = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      strobe_cycles = 0;
      write_cycles  = 0;
    end else if (bus.mcRamReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got mcRamReady=1 with no request pending (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("ready_cycle", cyc, mon_e.ready_cyc);
        check("fault", {31'd0, bus.mcFault}, {31'd0, mon_e.fault});
        check("rdata", bus.mcRamOut, mon_e.data);
        check("debug", bus.debug, mon_e.debug);
        check("ph_strobe_seen", {31'd0, strobe_cycles != 0}, {31'd0, mon_e.strobes});
        check("ph_write_seen", {31'd0, write_cycles != 0}, {31'd0, mon_e.wrote});
      end
      strobe_cycles = 0;
      write_cycles  = 0;
    end else begin
      if (bus.phReadReq || bus.phWriteReq) strobe_cycles++;
      if (bus.phWriteReq) write_cycles++;
    end
  end

  function automatic int unsigned sat(input int unsigned v);
    return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
  endfunction

  task automatic model_clear_tlb();
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endtask

  task automatic model(input bit virt, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit flush_fill, input int unsigned t, output exp_t e);
    int unsigned vpn, idx, off, phys, ent, d;
    logic [31:0] w0, w1;
    bit ok;
    vpn = addr >> 10;
    off = addr & 32'h3FF;
    idx = vpn % 16;
    ok = 1'b1;
    phys = addr;
    e.fault = 1'b0;
    e.strobes = 1'b1;
    e.wrote = 1'b0;
    if (!virt) begin
      d = L;
    end else if (vpn >= 256) begin
      e.fault = 1'b1; e.strobes = 1'b0; ok = 1'b0; d = 1;
    end else if (m_v[idx] && m_tag[idx] == vpn) begin
      hits = sat(hits);
      if (wr && !m_w[idx]) begin
        e.fault = 1'b1; e.strobes = 1'b0; ok = 1'b0; d = 1;
      end else begin
        phys = (m_ppn[idx] << 10) | off;
        d = L;
      end
    end else begin
      misses = sat(misses);
      ent = PT_BASE + vpn * 8;
      w0 = ref_mem[(ent >> 2) & 4095];
      if (!w0[31] || (wr && !w0[30])) begin
        e.fault = 1'b1; ok = 1'b0; d = L + 1;
      end else begin
        w1 = ref_mem[((ent + 4) >> 2) & 4095];
        m_v[idx] = 1'b1;
        m_tag[idx] = vpn;
        m_ppn[idx] = w1 & 32'h3FFFFF;
        m_w[idx] = w0[30];
        phys = (m_ppn[idx] << 10) | off;
        d = 3 * L;
      end
    end
    if (flush_fill) model_clear_tlb();
    if (ok) begin
      if (wr) begin
        ref_mem[(phys >> 2) & 4095] = data;
        e.wrote = 1'b1;
      end else begin
        last_out = ref_mem[(phys >> 2) & 4095];
      end
    end
    e.data = last_out;
    e.debug = {misses[15:0], hits[15:0]};
    e.ready_cyc = t + d;
  endtask

  task automatic do_req(input bit virt, input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] data, input bit flush_fill);
    exp_t e;
    int unsigned t;
    t = cyc + 1;
    model(virt, wr && !both, addr, data, flush_fill, t, e);
    q.push_back(e);
    bus.mcAddrVirtual = virt;
    bus.mcRamAddress  = addr;
    bus.mcRamIn       = data;
    bus.mcReadReq     = !wr || both;
    bus.mcWriteReq    = wr;
    @(negedge clk);
    bus.mcReadReq    = 1'b0;
    bus.mcWriteReq   = 1'b0;
    bus.mcRamAddress = $urandom();
    if (flush_fill) begin
      while (cyc < t + 2 * L - 1) @(negedge clk);
      bus.tlbFlush = 1'b1;
      @(negedge clk);
      bus.tlbFlush = 1'b0;
    end
    for (int i = 0; i < 60 && !bus.mcRamReady; i++) @(negedge clk);
    if (!bus.mcRamReady) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no mcRamReady within 60 cycles, required one by cycle %0d", e.ready_cyc);
      q.delete();
    end
  endtask

  task automatic do_flush();
    bus.tlbFlush = 1'b1;
    @(negedge clk);
    bus.tlbFlush = 1'b0;
    model_clear_tlb();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mcRamOut"}, bus.mcRamOut, 32'd0);
    check({tag, "_mcRamReady"}, {31'd0, bus.mcRamReady}, 32'd0);
    check({tag, "_mcFault"}, {31'd0, bus.mcFault}, 32'd0);
    check({tag, "_phRamAddress"}, bus.phRamAddress, 32'd0);
    check({tag, "_phRamOut"}, bus.phRamOut, 32'd0);
    check({tag, "_ph_strobes"}, {30'd0, bus.phReadReq, bus.phWriteReq}, 32'd0);
    check({tag, "_debug"}, bus.debug, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] w0;
    reset = 1'b0;
    bus.mcRamAddress = '0; bus.mcRamIn = '0; bus.mcReadReq = 1'b0; bus.mcWriteReq = 1'b0;
    bus.mcAddrVirtual = 1'b0; bus.ptAddress = PT_BASE; bus.tlbFlush = 1'b0;
    model_clear_tlb();

    for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom();
    ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
    for (int v = 0; v < 256; v++) begin
      w0 = $urandom();
      w0[31] = ($urandom_range(5) != 0);
      ref_mem[(PT_BASE >> 2) + 2 * v]     = w0;
      ref_mem[(PT_BASE >> 2) + 2 * v + 1] = $urandom_range(7);
    end
    ref_mem[(PT_BASE >> 2) + 6]  = 32'h8000_0000; ref_mem[(PT_BASE >> 2) + 7]  = 32'd7;
    ref_mem[(PT_BASE >> 2) + 10] = 32'h8000_0000; ref_mem[(PT_BASE >> 2) + 11] = 32'd2;
    ref_mem[(PT_BASE >> 2) + 18] = 32'hC000_0000; ref_mem[(PT_BASE >> 2) + 19] = 32'd4;
    ref_mem[(PT_BASE >> 2) + 20] = 32'hC000_0000; ref_mem[(PT_BASE >> 2) + 21] = 32'd6;
    ref_mem[(PT_BASE >> 2) + 24] = 32'h4000_0000; ref_mem[(PT_BASE >> 2) + 25] = 32'd1;

    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      init_a = 12'(i); init_d = ref_mem[i]; init_we = 1'b1;
      @(negedge clk);
    end
    init_we = 1'b0;
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    do_req(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);               // physical read DEADBEEF
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_0C04, 32'h0, 1'b0);               // miss -> 0x1C04
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_0C04, 32'h0, 1'b0);               // hit
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_1410, 32'h1111_2222, 1'b0);       // PT protection fault
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_1410, 32'h0, 1'b0);               // not filled: misses again
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_0C08, 32'h3333_4444, 1'b0);       // hit protection fault
    do_req(1'b1, 1'b0, 1'b0, 32'h0004_0000, 32'h0, 1'b0);               // range fault
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0);               // PT-invalid fault
    do_flush();
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_0C04, 32'h0, 1'b0);               // miss after flush
    do_req(1'b1, 1'b1, 1'b0, 32'h0000_2420, 32'hCAFE_F00D, 1'b1);       // flush on fill edge
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_2420, 32'h0, 1'b0);               // misses, reads written data
    do_req(1'b1, 1'b1, 1'b1, 32'h0000_2420, 32'h5555_AAAA, 1'b0);       // both strobes: read

    // reset while in PT_WAIT0
    bus.mcAddrVirtual = 1'b1; bus.mcRamAddress = 32'h0000_2800; bus.mcReadReq = 1'b1;
    @(negedge clk);
    bus.mcReadReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    model_clear_tlb();
    hits = 0; misses = 0; last_out = '0;
    repeat (10) @(negedge clk);
    do_req(1'b1, 1'b0, 1'b0, 32'h0000_2800, 32'h0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(99);
      if (r < 5) begin
        do_flush();
      end else if (r < 20) begin
        do_req(1'b0, $urandom_range(1) == 1, $urandom_range(9) == 0,
               $urandom() & 32'h1FFC, $urandom(), 1'b0);
      end else begin
        int unsigned vpn;
        vpn = ($urandom_range(19) == 0) ? 256 + $urandom_range(999) : $urandom_range(255);
        do_req(1'b1, $urandom_range(99) < 40, $urandom_range(9) == 0,
               (vpn << 10) | ($urandom_range(255) << 2), $urandom(), 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
